// File: rtl/bus_distributor_if.sv
// Handshake bundle for bus_distributor: one input word stream, BUS_NO output lanes.
// slave = distributor side, master = source/consumer side.
interface bus_distributor_if #(
  parameter int BUS_NO = 4
) ();
  localparam int SEL_W = $clog2(BUS_NO);

  logic [31:0]        in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [32*BUS_NO-1:0] out_data;
  logic [BUS_NO-1:0]  out_valid;
  logic [BUS_NO-1:0]  out_ready;
  logic               err_sel;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel
  );
endinterface

// File: rtl/bus_distributor.sv
// Steers a 32-bit word stream into BUS_NO one-entry lane registers with valid/ready per lane.
// Optional macro BUS_DISTRIBUTOR_ROUND_ROBIN_EN: ignore in_sel and rotate lanes with an internal pointer.
module bus_distributor #(
  parameter int BUS_NO = 4
) (
  input  logic             clk,
  input  logic             rst,
  bus_distributor_if.slave bus
);
  localparam int SEL_W = $clog2(BUS_NO);

  logic [SEL_W-1:0]            dest;
  logic [BUS_NO-1:0]           hit;
  logic [BUS_NO-1:0]           load;
  logic [BUS_NO-1:0]           stall;
  logic [BUS_NO-1:0]           valid_q, valid_d;
  logic [BUS_NO-1:0][31:0]     data_q, data_d;
  logic                        err_q, err_d;
  logic                        xfer;

`ifdef BUS_DISTRIBUTOR_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  assign dest  = ptr_q;
  assign ptr_d = !xfer ? ptr_q :
                 (ptr_q == SEL_W'(BUS_NO - 1)) ? '0 : ptr_q + 1'b1;
  assign err_d = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign dest = bus.in_sel;
`endif

  // A lane blocks the input only when it is the target, full, and not draining.
  for (genvar gi = 0; gi < BUS_NO; gi++) begin : g_lane
    assign hit[gi]     = (dest == SEL_W'(gi));
    assign load[gi]    = xfer & hit[gi];
    assign stall[gi]   = hit[gi] & valid_q[gi] & ~bus.out_ready[gi];
    assign valid_d[gi] = load[gi] | (valid_q[gi] & ~bus.out_ready[gi]);
    assign data_d[gi]  = load[gi] ? bus.in_data : data_q[gi];
  end

  assign bus.in_ready = ~rst & ~(|stall);
  assign xfer         = bus.in_valid & bus.in_ready;

`ifndef BUS_DISTRIBUTOR_ROUND_ROBIN_EN
  // No lane matches an out-of-range select: the word is swallowed and flagged.
  assign err_d = xfer & ~(|hit);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.err_sel   = err_q;
endmodule
